// File: rtl/clk_sched_pkg.sv
// Shared definitions for the clock-enable scheduler: mode encodings,
// FSM state encoding, default widths and the mode-resolution helper.
package clk_sched_pkg;

  localparam int DIV_W_DEF = 5;
  localparam int CNT_W_DEF = 32;

  // Encoding of cfg_mode / cur_mode
  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  // Scheduler FSM; PEND is RUN with a configuration waiting for the next pulse
  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_PEND = 2'b11
  } state_e;

  // Map a requested mode onto the state it lands in; reserved (and STEP when
  // stepping is not built in) collapse to HALT
  function automatic state_e mode_to_state(input logic [1:0] mode, input logic step_en);
    state_e st;
    st = ST_HALT;
    case (mode)
      MODE_RUN:  st = ST_RUN;
      MODE_STEP: st = step_en ? ST_STEP : ST_HALT;
      default:   st = ST_HALT;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/step_edge_det.sv
// Single-bit rising-edge detector for the step button level.
// o_rise is high while i_level is 1 and its previous registered sample was 0.
module step_edge_det (
  input  logic clockin,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  // Remember last cycle's level so a held button yields a single rise
  always_ff @(posedge clockin or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: issues clk_en pulses every 2^cur_div cycles in RUN,
// single pulses on step_req rising edges in STEP, nothing in HALT.
// Configurations arriving in RUN are held until the next pulse so the
// period in flight is never cut short.
// Build option: define CLK_SCHED_STEP_EN to include STEP mode and the
// step_req edge detector; otherwise STEP requests are treated as HALT.
module clk_en_sched
  import clk_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clockin,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             step_req,
  output logic             clk_en,
  output logic [1:0]       cur_mode,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy
);

`ifdef CLK_SCHED_STEP_EN
  localparam logic STEP_EN = 1'b1;
`else
  localparam logic STEP_EN = 1'b0;
`endif

  state_e           r_state, w_state_next;
  state_e           r_pend_state, w_pend_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_mask;
  logic [DIV_W-1:0] r_cur_div, w_cur_div_next;
  logic [DIV_W-1:0] r_pend_div, w_pend_div_next;
  logic             r_clk_en, w_clk_en_next;
  logic             w_step_rise, w_accept, w_tick;

`ifdef CLK_SCHED_STEP_EN
  step_edge_det u_step_edge_det (
    .clockin(clockin),
    .rst_n  (rst_n),
    .i_level(step_req),
    .o_rise (w_step_rise)
  );
`else
  logic w_unused_step;
  assign w_unused_step = step_req;
  assign w_step_rise   = 1'b0;
`endif

  assign w_mask   = (CNT_W'(1) << r_cur_div) - CNT_W'(1);
  assign w_tick   = ((r_state == ST_RUN) || (r_state == ST_PEND)) && ((r_cnt & w_mask) == w_mask);
  assign w_accept = cfg_valid && (r_state != ST_PEND);

  // Next-state logic: immediate apply from HALT/STEP, deferred apply from RUN
  always_comb begin
    w_state_next      = r_state;
    w_pend_state_next = r_pend_state;
    w_pend_div_next   = r_pend_div;
    w_cur_div_next    = r_cur_div;
    w_cnt_next        = r_cnt;
    w_clk_en_next     = 1'b0;
    case (r_state)
      ST_HALT: begin
        w_cnt_next = '0;
        if (w_accept) begin
          w_state_next   = mode_to_state(cfg_mode, STEP_EN);
          w_cur_div_next = cfg_div;
        end
      end
      ST_STEP: begin
        w_cnt_next = '0;
        if (w_accept) begin
          w_state_next   = mode_to_state(cfg_mode, STEP_EN);
          w_cur_div_next = cfg_div;
        end else begin
          w_clk_en_next = w_step_rise;
        end
      end
      ST_RUN: begin
        w_cnt_next    = r_cnt + CNT_W'(1);
        w_clk_en_next = w_tick;
        if (w_accept) begin
          w_state_next      = ST_PEND;
          w_pend_state_next = mode_to_state(cfg_mode, STEP_EN);
          w_pend_div_next   = cfg_div;
        end
      end
      ST_PEND: begin
        w_cnt_next    = r_cnt + CNT_W'(1);
        w_clk_en_next = w_tick;
        if (w_tick) begin
          w_state_next   = r_pend_state;
          w_cur_div_next = r_pend_div;
          w_cnt_next     = '0;
        end
      end
      default: begin
        w_state_next = ST_HALT;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, counter, configuration and pulse registers
  always_ff @(posedge clockin or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_HALT;
      r_pend_state <= ST_HALT;
      r_pend_div   <= '0;
      r_cur_div    <= '0;
      r_cnt        <= '0;
      r_clk_en     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pend_state <= w_pend_state_next;
      r_pend_div   <= w_pend_div_next;
      r_cur_div    <= w_cur_div_next;
      r_cnt        <= w_cnt_next;
      r_clk_en     <= w_clk_en_next;
    end
  end

  // Report the mode in effect; PEND still runs the old RUN configuration
  always_comb begin
    cur_mode = MODE_HALT;
    case (r_state)
      ST_RUN, ST_PEND: cur_mode = MODE_RUN;
      ST_STEP:         cur_mode = MODE_STEP;
      default:         cur_mode = MODE_HALT;
    endcase
  end

  assign clk_en    = r_clk_en;
  assign cur_div   = r_cur_div;
  assign busy      = (r_state == ST_PEND);
  assign cfg_ready = (r_state != ST_PEND);

endmodule

// File: tb/tb_clk_en_sched.sv
// Self-checking bench for clk_en_sched: a fixed vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_clk_en_sched;

  localparam int DIV_W = 5;
  localparam int CNT_W = 32;

`ifdef CLK_SCHED_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic             clockin;
  logic             rst_n;
  logic             cfgValid;
  logic             cfgReady;
  logic [1:0]       cfgMode;
  logic [DIV_W-1:0] cfgDiv;
  logic             stepReq;
  logic             clkEn;
  logic [1:0]       curMode;
  logic [DIV_W-1:0] curDiv;
  logic             busy;

  int nTests = 0;
  int nFail  = 0;

  // Behavioural model state
  logic [1:0]       mMode;
  logic [DIV_W-1:0] mDiv;
  longint unsigned  mAge;
  bit               mPend;
  logic [1:0]       mPendMode;
  logic [DIV_W-1:0] mPendDiv;
  bit               mClkEn;
  bit               mPrev;

  typedef struct {
    logic             v;
    logic [1:0]       md;
    logic [DIV_W-1:0] dv;
    logic             eClk;
    logic [1:0]       eMode;
    logic [DIV_W-1:0] eDiv;
    logic             eBusy;
  } vec_t;

  vec_t tbl[15];

  clk_en_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clockin  (clockin),
    .rst_n    (rst_n),
    .cfg_valid(cfgValid),
    .cfg_ready(cfgReady),
    .cfg_mode (cfgMode),
    .cfg_div  (cfgDiv),
    .step_req (stepReq),
    .clk_en   (clkEn),
    .cur_mode (curMode),
    .cur_div  (curDiv),
    .busy     (busy)
  );

  initial clockin = 1'b0;
  always #5 clockin = ~clockin;

  // Generic comparison
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model
  task automatic checkOutput(input string name);
    checkVal(name, {22'd0, clkEn, curMode, curDiv, busy, cfgReady},
             {22'd0, mClkEn, mMode, mDiv, mPend, ~mPend});
  endtask

  // Apply a configuration to the model: resolved mode, fresh period
  task automatic modelApply(input logic [1:0] md, input logic [DIV_W-1:0] dv);
    if (md == 2'b01)                 mMode = 2'b01;
    else if (md == 2'b10 && STEP_EN) mMode = 2'b10;
    else                             mMode = 2'b00;
    mDiv  = dv;
    mAge  = 0;
    mPend = 0;
  endtask

  // One clock edge of the model given the inputs seen at that edge
  task automatic modelEdge(input logic v, input logic [1:0] md, input logic [DIV_W-1:0] dv,
                           input logic st);
    bit rise;
    bit tick;
    longint unsigned period;
    rise  = st && !mPrev;
    mPrev = st;
    mClkEn = 0;
    if (mMode == 2'b00) begin
      if (v) modelApply(md, dv);
    end else if (mMode == 2'b10) begin
      if (v) modelApply(md, dv);
      else   mClkEn = rise;
    end else begin
      period = 64'd1 << mDiv;
      tick   = ((mAge % period) == period - 1);
      mClkEn = tick;
      if (mPend && tick) begin
        modelApply(mPendMode, mPendDiv);
      end else begin
        mAge++;
        if (!mPend && v) begin
          mPend     = 1;
          mPendMode = md;
          mPendDiv  = dv;
        end
      end
    end
  endtask

  // Drive inputs, let one rising edge pass, step the model, settle
  task automatic applyStimulus(input logic v, input logic [1:0] md, input logic [DIV_W-1:0] dv,
                               input logic st);
    cfgValid = v;
    cfgMode  = md;
    cfgDiv   = dv;
    stepReq  = st;
    @(posedge clockin);
    modelEdge(v, md, dv, st);
    #1;
  endtask

  // Asynchronous reset with an immediate check of the reset outputs
  task automatic doReset(input string name);
    cfgValid = 0;
    cfgMode  = 0;
    cfgDiv   = 0;
    stepReq  = 0;
    rst_n    = 0;
    #2;
    checkVal(name, {22'd0, clkEn, curMode, curDiv, busy, cfgReady}, 32'd1);
    @(negedge clockin);
    rst_n     = 1;
    mMode     = 0;
    mDiv      = 0;
    mAge      = 0;
    mPend     = 0;
    mPendMode = 0;
    mPendDiv  = 0;
    mClkEn    = 0;
    mPrev     = 0;
  endtask

  initial begin
    int pulses;
    int firstIdx;
    int n;

    rst_n = 0;
    tbl[0]  = '{1'b1, 2'b01, 5'd1, 1'b0, 2'b01, 5'd1, 1'b0};
    tbl[1]  = '{1'b0, 2'b00, 5'd0, 1'b0, 2'b01, 5'd1, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 5'd0, 1'b1, 2'b01, 5'd1, 1'b0};
    tbl[3]  = '{1'b1, 2'b01, 5'd0, 1'b0, 2'b01, 5'd1, 1'b1};
    tbl[4]  = '{1'b1, 2'b00, 5'd2, 1'b1, 2'b01, 5'd0, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 5'd0, 1'b1, 2'b01, 5'd0, 1'b0};
    tbl[6]  = '{1'b1, 2'b11, 5'd3, 1'b1, 2'b01, 5'd0, 1'b1};
    tbl[7]  = '{1'b0, 2'b00, 5'd0, 1'b1, 2'b00, 5'd3, 1'b0};
    tbl[8]  = '{1'b0, 2'b00, 5'd0, 1'b0, 2'b00, 5'd3, 1'b0};
    tbl[9]  = '{1'b1, 2'b01, 5'd2, 1'b0, 2'b01, 5'd2, 1'b0};
    tbl[10] = '{1'b0, 2'b00, 5'd0, 1'b0, 2'b01, 5'd2, 1'b0};
    tbl[11] = '{1'b0, 2'b00, 5'd0, 1'b0, 2'b01, 5'd2, 1'b0};
    tbl[12] = '{1'b0, 2'b00, 5'd0, 1'b0, 2'b01, 5'd2, 1'b0};
    tbl[13] = '{1'b0, 2'b00, 5'd0, 1'b1, 2'b01, 5'd2, 1'b0};
    tbl[14] = '{1'b0, 2'b00, 5'd0, 1'b0, 2'b01, 5'd2, 1'b0};

    // Fixed vector table from reset
    doReset("reset_table");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].v, tbl[i].md, tbl[i].dv, 1'b0);
      checkVal($sformatf("table_row%0d", i),
               {22'd0, clkEn, curMode, curDiv, busy, cfgReady},
               {22'd0, tbl[i].eClk, tbl[i].eMode, tbl[i].eDiv, tbl[i].eBusy, ~tbl[i].eBusy});
    end

    // RUN div=0 accepted at cycle 0: enable every cycle from cycle 1
    doReset("reset_div0");
    applyStimulus(1'b1, 2'b01, 5'd0, 1'b0);
    checkVal("div0_mode", {30'd0, curMode}, 32'd1);
    checkVal("div0_first_en", {31'd0, clkEn}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 2'b00, 5'd0, 1'b0);
      checkVal($sformatf("div0_en_c%0d", i), {31'd0, clkEn}, 32'd1);
    end

    // RUN div=2, then div=4 offered mid-period
    doReset("reset_div2");
    applyStimulus(1'b1, 2'b01, 5'd2, 1'b0);
    for (int i = 0; i < 10 && !clkEn; i++) applyStimulus(1'b0, 2'b00, 5'd0, 1'b0);
    checkVal("div2_pulse_seen", {31'd0, clkEn}, 32'd1);
    applyStimulus(1'b1, 2'b01, 5'd4, 1'b0);
    checkVal("div4_busy", {30'd0, busy, cfgReady}, 32'b10);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'b00, 5'd0, 1'b0);
      if (clkEn) break;
      checkOutput("div4_pending");
    end
    checkVal("div4_apply", {22'd0, clkEn, curMode, curDiv, busy, cfgReady}, {22'd0, 1'b1, 2'b01, 5'd4, 1'b0, 1'b1});
    n = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 2'b00, 5'd0, 1'b0);
      n++;
      if (clkEn) break;
    end
    checkVal("div4_first_pulse_gap", n, 32'd16);

`ifdef CLK_SCHED_STEP_EN
    // STEP: held press gives one pulse, re-press gives one more
    doReset("reset_step");
    applyStimulus(1'b1, 2'b10, 5'd0, 1'b0);
    checkVal("step_mode", {30'd0, curMode}, 32'd2);
    pulses   = 0;
    firstIdx = -1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'b00, 5'd0, 1'b1);
      if (clkEn) begin
        pulses++;
        if (firstIdx < 0) firstIdx = i;
      end
    end
    checkVal("step_hold_pulses", pulses, 32'd1);
    checkVal("step_pulse_latency", firstIdx, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 5'd0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2'b00, 5'd0, 1'b1);
      if (clkEn) pulses++;
    end
    checkVal("step_repress_pulses", pulses, 32'd1);
`else
    // STEP not built in: request lands in HALT and step_req does nothing
    doReset("reset_nostep");
    applyStimulus(1'b1, 2'b10, 5'd0, 1'b0);
    checkVal("nostep_mode", {30'd0, curMode}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 2'b00, 5'd0, i[0]);
      if (clkEn) pulses++;
    end
    checkVal("nostep_pulses", pulses, 32'd0);
`endif

    // Reserved mode behaves as HALT for 100 cycles
    doReset("reset_rsvd");
    applyStimulus(1'b1, 2'b11, 5'd0, 1'b0);
    checkVal("rsvd_mode", {30'd0, curMode}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 2'b00, 5'd0, i[1]);
      if (clkEn) pulses++;
    end
    checkVal("rsvd_pulses", pulses, 32'd0);

    // Reset while a configuration is pending in RUN div=3
    doReset("reset_pre_busy");
    applyStimulus(1'b1, 2'b01, 5'd3, 1'b0);
    applyStimulus(1'b0, 2'b00, 5'd0, 1'b0);
    applyStimulus(1'b1, 2'b00, 5'd1, 1'b0);
    checkVal("busy_before_reset", {31'd0, busy}, 32'd1);
    doReset("reset_while_busy");
    applyStimulus(1'b0, 2'b00, 5'd0, 1'b0);
    checkVal("after_reset_idle", {22'd0, clkEn, curMode, curDiv, busy, cfgReady}, 32'd1);

    // Randomized run against the model
    doReset("reset_random");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/clk_en_sched.md
CLK_EN_SCHED -- requirements
Module: clk_en_sched

Interface
REQ-001 Parameter DIV_W, default 5: width of the log2-divisor field; divide ratio is 2^cfg_div.
REQ-002 Parameter CNT_W, default 32: width of the internal period counter; SHALL be >= 2^DIV_W.
REQ-003 clockin  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 cfg_valid  in  1  new configuration offered.
REQ-006 cfg_ready  out  1  configuration can be accepted; a transfer occurs when cfg_valid && cfg_ready on a rising edge.
REQ-007 cfg_mode  in  2  requested mode: 00 HALT, 01 RUN, 10 STEP, 11 reserved.
REQ-008 cfg_div  in  DIV_W  requested log2 divisor for RUN.
REQ-009 step_req  in  1  synchronous single-step request level, e.g. a debounced button.
REQ-010 clk_en  out  1  registered clock-enable pulse for the core datapath.
REQ-011 cur_mode  out  2  mode currently in effect.
REQ-012 cur_div  out  DIV_W  divisor currently in effect.
REQ-013 busy  out  1  an accepted configuration is pending and not yet applied.

Function
REQ-014 FSM states: HALT, RUN, STEP, PEND. PEND records a pending configuration alongside RUN and reflects busy=1.
- HALT: clk_en=0, counter held at 0.
- RUN: counter increments every cycle, wrapping at 2^CNT_W.
- clk_en=1 in the cycle after the counter's low cur_div bits are all ones.
- With cur_div=0, clk_en=1 every cycle.
REQ-015 Reserved mode 11 SHALL be applied as HALT.
REQ-016 cfg_ready=1 whenever busy=0; cfg_ready=0 while busy=1, so at most one pending configuration exists.
REQ-017 Apply timing for an accepted configuration:
- If the current mode is HALT or STEP, apply it on the next edge (1-cycle latency).
- If the current mode is RUN, hold it pending (busy=1) and apply it on the edge on which clk_en=1 is issued under the old configuration.
REQ-018 Applying a configuration SHALL:
- clear the counter;
- update cur_mode and cur_div;
- clear busy.
REQ-019 If the apply edge and a clk_en pulse coincide, the pulse SHALL belong to the old configuration; the first pulse under the new configuration SHALL follow 2^new_div cycles later.
REQ-020 STEP: a rising edge of step_req (sampled 1 while its previous registered sample was 0) SHALL produce exactly one clk_en=1 cycle on the following cycle; holding step_req high SHALL produce no further pulses.
REQ-021 step_req SHALL be ignored in HALT and RUN. A step edge on the same edge that leaves STEP SHALL be dropped.
REQ-022 clk_en SHALL never be high for two consecutive cycles except in RUN with cur_div=0.

Reset
REQ-023 On rst_n=0, asynchronously:
- clk_en=0, busy=0, cfg_ready=1;
- cur_mode=HALT, cur_div=0;
- counter=0, step-edge register=0;
- any pending configuration discarded.
REQ-024 After rst_n deasserts, the block SHALL remain in HALT until a configuration is accepted.

Configuration
REQ-025 Macro CLK_SCHED_STEP_EN:
- Defined: STEP mode and step_req handling are compiled in.
- Undefined: cfg_mode 10 is applied as HALT, step_req is unused, and the edge detector is not instantiated; all ports remain present.

Structure
REQ-026 Package clk_sched_pkg SHALL hold the mode encodings (HALT/RUN/STEP/RSVD), the FSM state encoding, and the DIV_W/CNT_W defaults.
REQ-027 Sub-module step_edge_det (1-bit rising-edge detector, same clock and reset) SHALL implement REQ-020.

Verification
REQ-028 Reset, then cfg {RUN, div=0} accepted at cycle 0 -> clk_en=1 every cycle from cycle 1; cur_mode=01.
REQ-029 RUN div=2: clk_en pulses every 4 cycles. Cfg div=4 offered mid-period:
- busy=1 and cfg_ready=0 until the next pulse;
- the next pulse arrives 16 cycles after the apply edge.
REQ-030 STEP mode, step_req held high 10 cycles -> exactly one clk_en pulse, 1 cycle after the rising edge. Release then re-press -> one more pulse.
REQ-031 cfg_mode=11 -> cur_mode=HALT and clk_en stays 0 for 100 cycles. Second cfg_valid while busy=1 -> not accepted; the first configuration is applied unchanged.
REQ-032 rst_n asserted while busy=1 in RUN div=3 -> outputs go to reset values immediately; after release, clk_en=0 and cfg_ready=1.
REQ-033 Build without CLK_SCHED_STEP_EN, cfg {STEP}, toggle step_req -> cur_mode=HALT and no clk_en pulses.
